// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer.
// Adds two WIDTH-bit unsigned operands LSB first through a single full-adder
// slice (two half-adder stages plus a carry flop), one bit per clock, behind a
// start/done handshake. The visible sum/cout only change when a new result is
// complete; the running sum is built in a separate shadow shift register.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Half adder: returns {carry, sum}.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        half_add = {x & y, x ^ y};
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] sum_sh_r;
    logic             carry_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    logic [1:0]       ha1_s;
    logic [1:0]       ha2_s;
    logic             sum_bit_s;
    logic             carry_next_s;

    // Full-adder slice on the current LSBs: two half adders, carries ORed.
    always_comb begin
        ha1_s        = 2'b00;
        ha2_s        = 2'b00;
        sum_bit_s    = 1'b0;
        carry_next_s = 1'b0;
        ha1_s        = half_add(a_sh_r[0], b_sh_r[0]);
        ha2_s        = half_add(ha1_s[0], carry_r);
        sum_bit_s    = ha2_s[0];
        carry_next_s = ha1_s[1] | ha2_s[1];
    end

    // Sequencer FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            sum_sh_r <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            sum_r    <= {WIDTH{1'b0}};
            cout_r   <= 1'b0;
        end else begin
            // Outputs follow the state one edge later, so busy and done can
            // never overlap and done is a single-cycle pulse.
            busy_r <= (state_r == ST_RUN);
            done_r <= (state_r == ST_DONE);

            // Publish the finished result only when leaving DONE; during a
            // following RUN the previous result stays visible.
            if (state_r == ST_DONE) begin
                sum_r  <= sum_sh_r;
                cout_r <= carry_r;
            end else begin
                sum_r  <= sum_r;
                cout_r <= cout_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_sh_r   <= a;
                        b_sh_r   <= b;
                        sum_sh_r <= {WIDTH{1'b0}};
                        carry_r  <= 1'b0;
                        cnt_r    <= {CNT_W{1'b0}};
                        state_r  <= ST_RUN;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
                    sum_sh_r <= {sum_bit_s, sum_sh_r[WIDTH-1:1]};
                    carry_r  <= carry_next_s;
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    // Back-to-back request is accepted exactly as from IDLE.
                    if (start) begin
                        a_sh_r   <= a;
                        b_sh_r   <= b;
                        sum_sh_r <= {WIDTH{1'b0}};
                        carry_r  <= 1'b0;
                        cnt_r    <= {CNT_W{1'b0}};
                        state_r  <= ST_RUN;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule
